// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift unit: op codes, FSM states, width.
// Latency: none (constants and a pure helper function).
// Backpressure: not applicable.
package shift_pkg;

  localparam int SH_W = 8;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  // Number of single-bit steps to perform. Linear shifts saturate at the
  // operand width (further steps would not change the result); rotates wrap.
  function automatic logic [3:0] eff_amount(input logic [1:0] op, input logic [7:0] amt);
    logic [3:0] n;
    if (op == OP_ROR) begin
      n = {1'b0, amt[2:0]};
    end else if (amt >= 8'd8) begin
      n = 4'd8;
    end else begin
      n = amt[3:0];
    end
    return n;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate of the working value, selected by the op code.
// Latency: combinational.
// Backpressure: not applicable.
module shift_step
  import shift_pkg::*;
(
  input  logic [1:0]      op,
  input  logic [SH_W-1:0] din,
  output logic [SH_W-1:0] dout
);

  // One position per step; SRA replicates the sign bit, ROR wraps bit 0 to the top.
  always_comb begin
    dout = din;
    case (op)
      OP_SLL:  dout = {din[SH_W-2:0], 1'b0};
      OP_SRL:  dout = {1'b0, din[SH_W-1:1]};
      OP_SRA:  dout = {din[SH_W-1], din[SH_W-1:1]};
      OP_ROR:  dout = {din[0], din[SH_W-1:1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit moving the operand one bit per clock.
// Latency: N+1 cycles from acceptance to DONE (N = effective shift amount).
// Backpressure: START is accepted only in IDLE or FIN; requests while BUSY are dropped.
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = SH_W
)
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic [7:0]       SHIFT,
  input  logic [1:0]       OP,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             DONE
);

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [3:0]       count;
  logic [3:0]       n_next;
  logic [WIDTH-1:0] step_out;

  assign n_next = eff_amount(OP, SHIFT);

  shift_step u_step (
    .op   (op_q),
    .din  (RESULT),
    .dout (step_out)
  );

  // FSM, step counter and result register; BUSY/DONE are registered so no
  // input reaches them combinationally.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      op_q   <= OP_SLL;
      count  <= 4'd0;
      RESULT <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state == ST_SHIFT) begin
        RESULT <= step_out;
        count  <= count - 4'd1;
        if (count == 4'd1) begin
          state <= ST_FIN;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
        end
      end else if (START) begin
        op_q   <= OP;
        RESULT <= DATA_IN;
        count  <= n_next;
        if (n_next != 4'd0) begin
          state <= ST_SHIFT;
          BUSY  <= 1'b1;
        end else begin
          state <= ST_FIN;
          DONE  <= 1'b1;
        end
      end else begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Scoreboard bench: stimulus pushes expected results, a monitor checks each DONE.
// Latency: checks BUSY run length equals the effective shift amount.
// Backpressure: new operations are issued only after the previous DONE.
module tb_iter_shift_unit;
  import shift_pkg::*;

  typedef struct {
    logic [7:0] res;
    int         n;
  } exp_t;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [7:0] DATA_IN;
  logic [7:0] SHIFT;
  logic [1:0] OP;
  logic [7:0] RESULT;
  logic       BUSY;
  logic       DONE;

  int   compared   = 0;
  int   mismatched = 0;
  int   busy_run   = 0;
  exp_t sb[$];

  iter_shift_unit #(.WIDTH(8)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START   (START),
    .DATA_IN (DATA_IN),
    .SHIFT   (SHIFT),
    .OP      (OP),
    .RESULT  (RESULT),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model straight from the operation rules.
  function automatic logic [7:0] model_res(input logic [7:0] d, input logic [7:0] a, input logic [1:0] o);
    logic signed [7:0] s;
    int r;
    s = d;
    case (o)
      OP_SLL:  return (a >= 8) ? 8'h00 : 8'(d << a);
      OP_SRL:  return (a >= 8) ? 8'h00 : 8'(d >> a);
      OP_SRA:  return (a >= 8) ? {8{d[7]}} : 8'(s >>> a);
      default: begin
        r = int'(a) % 8;
        return 8'((d >> r) | (d << (8 - r)));
      end
    endcase
  endfunction

  function automatic int model_n(input logic [7:0] a, input logic [1:0] o);
    if (o == OP_ROR) return int'(a) % 8;
    return (a >= 8) ? 8 : int'(a);
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    exp_t e;
    if (RESET) begin
      busy_run = 0;
    end else begin
      compared++;
      if (BUSY && DONE) begin
        mismatched++;
        $display("FAIL busy_done_overlap: BUSY=%b DONE=%b, required not both high", BUSY, DONE);
      end
      if (BUSY === 1'b1) busy_run++;
      if (DONE === 1'b1) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL spurious_done: DONE seen with RESULT=%h, no operation pending", RESULT);
        end else begin
          e = sb.pop_front();
          compared++;
          if (RESULT !== e.res) begin
            mismatched++;
            $display("FAIL result: got %h, required %h", RESULT, e.res);
          end
          if (busy_run != e.n) begin
            mismatched++;
            $display("FAIL busy_cycles: got %0d, required %0d", busy_run, e.n);
          end
        end
        busy_run = 0;
      end
    end
  end

  // Drive one request; it is accepted at the next edge (unit is IDLE or FIN).
  task automatic issue(input logic [7:0] d, input logic [7:0] a, input logic [1:0] o,
                       input logic [7:0] er, input int en);
    exp_t e;
    @(posedge CLK);
    #1;
    DATA_IN = d; SHIFT = a; OP = o; START = 1'b1;
    @(posedge CLK);
    e.res = er; e.n = en;
    sb.push_back(e);
    #1;
    START = 1'b0;
  endtask

  // Returns at the falling edge of the DONE cycle, bounded.
  task automatic wait_done(input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      compared++;
      mismatched++;
      $display("FAIL timeout_%s: DONE not seen within 300 cycles, required a DONE pulse", name);
    end
  endtask

  task automatic run(input logic [7:0] d, input logic [7:0] a, input logic [1:0] o,
                     input logic [7:0] er, input int en, input string name);
    issue(d, a, o, er, en);
    wait_done(name);
  endtask

  task automatic check_idle_outputs(input string name);
    compared++;
    if (RESULT !== 8'h00 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      mismatched++;
      $display("FAIL %s: RESULT=%h BUSY=%b DONE=%b, required 00 0 0", name, RESULT, BUSY, DONE);
    end
  endtask

  initial begin
    exp_t e;
    int   dones;
    logic [7:0] d, a;
    logic [1:0] o;

    RESET = 1'b1; START = 1'b0; DATA_IN = 8'h00; SHIFT = 8'h00; OP = OP_SLL;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check_idle_outputs("reset_state");

    // Directed cases with hand-derived expectations.
    run(8'hFF, 8'd3,   OP_SRA, 8'hFF, 3, "sra_neg1");
    run(8'h15, 8'd1,   OP_SRL, 8'h0A, 1, "srl_1");
    run(8'h15, 8'd3,   OP_SLL, 8'hA8, 3, "sll_3");
    run(8'h81, 8'd9,   OP_ROR, 8'hC0, 1, "ror_9");
    run(8'h81, 8'd8,   OP_ROR, 8'h81, 0, "ror_8");
    run(8'h80, 8'd200, OP_SRA, 8'hFF, 8, "sra_sat");
    run(8'h80, 8'd200, OP_SRL, 8'h00, 8, "srl_sat");
    run(8'h5A, 8'd0,   OP_SLL, 8'h5A, 0, "sll_0");

    // START pulsed mid-shift is ignored; START held in FIN is accepted.
    issue(8'h7F, 8'd5, OP_SRL, 8'h03, 5);
    @(posedge CLK);
    #1;
    DATA_IN = 8'hAA; SHIFT = 8'd1; OP = OP_SLL; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    wait_done("mid_start");
    DATA_IN = 8'h10; SHIFT = 8'd2; OP = OP_SLL; START = 1'b1;
    @(posedge CLK);
    e.res = 8'h40; e.n = 2;
    sb.push_back(e);
    #1;
    START = 1'b0;
    wait_done("back_to_back");

    // Reset in the 2nd shift cycle of a 6-step shift, with a coincident START.
    issue(8'hC3, 8'd6, OP_SRL, 8'h03, 6);
    @(posedge CLK);
    #1;
    RESET = 1'b1; START = 1'b1; DATA_IN = 8'h11; SHIFT = 8'd0; OP = OP_SLL;
    void'(sb.pop_back());
    @(posedge CLK);
    #1;
    RESET = 1'b0; START = 1'b0;
    @(negedge CLK);
    check_idle_outputs("mid_shift_reset");
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) dones++;
    end
    compared++;
    if (dones != 0) begin
      mismatched++;
      $display("FAIL no_done_after_reset: got %0d DONE pulses, required 0", dones);
    end

    // Randomized operations against the reference model.
    for (int k = 0; k < 200; k++) begin
      d = 8'($urandom);
      o = 2'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      run(d, a, o, model_res(d, a, o), model_n(a, o), "random");
    end

    repeat (3) @(negedge CLK);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
